systolic_pe_k: RTL and testbench

Parametrised output-stationary processing element, the next generation of the systolic MAC array cell. It accumulates `K_DEPTH` products of streamed operand pairs into one result per tile and forwards operands one cycle later to its east/south neighbours. It also provides configurable operand/accumulator widths, signed or unsigned arithmetic, saturating or wrapping accumulation, a sticky per-tile overflow flag, and an early-flush input for partial tiles. One instance sits at every grid point of the array; `y_out`/`y_valid` feed the array's result-collection logic.

---
 rtl/systolic_pe_k.sv | 110 +++++++++++
 tb/tb_systolic_pe_k.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_pe_k.sv
// Output-stationary systolic MAC cell: accumulates K_DEPTH operand products
// per tile, forwards operands east/south with one cycle of latency.
module systolic_pe_k #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int K_DEPTH  = 4,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             valid_in,
  input  logic [DATA_W-1:0]                a_in,
  input  logic [DATA_W-1:0]                b_in,
  input  logic                             flush,
  output logic [DATA_W-1:0]                a_out,
  output logic [DATA_W-1:0]                b_out,
  output logic                             valid_out,
  output logic [ACC_W-1:0]                 y_out,
  output logic                             y_valid,
  output logic                             overflow,
  output logic [$clog2(K_DEPTH+1)-1:0]     beat_cnt
);

  localparam int CW = $clog2(K_DEPTH+1);
  localparam int PW = 2*DATA_W;
  localparam int XW = ACC_W+1-PW;
  localparam logic SX = (SIGNED != 0);
  localparam logic SAT = (SATURATE != 0);
  localparam logic [CW-1:0] LAST = CW'(K_DEPTH-1);
  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] UMAX = {ACC_W{1'b1}};

  typedef enum logic {EMPTY, FILLING} state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic              ovf_acc;

  logic [PW-1:0]     a_ext;
  logic [PW-1:0]     b_ext;
  logic [PW-1:0]     prod;
  logic [ACC_W:0]    prod_ext;
  logic [ACC_W:0]    acc_ext;
  logic [ACC_W:0]    sum;
  logic              beat_ovf;
  logic [ACC_W-1:0]  sat_val;
  logic [ACC_W-1:0]  res;
  logic              closing;

  // Low PW bits of the product of extended operands equal the exact product.
  always_comb begin
    a_ext    = {{DATA_W{SX & a_in[DATA_W-1]}}, a_in};
    b_ext    = {{DATA_W{SX & b_in[DATA_W-1]}}, b_in};
    prod     = a_ext * b_ext;
    prod_ext = {{XW{SX & prod[PW-1]}}, prod};
    acc_ext  = {SX & acc[ACC_W-1], acc};
    sum      = acc_ext + prod_ext;
    beat_ovf = SX ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
    sat_val  = SX ? (sum[ACC_W] ? SMIN : SMAX) : UMAX;
    res      = (beat_ovf && SAT) ? sat_val : sum[ACC_W-1:0];
    closing  = valid_in && (flush || beat_cnt == LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      acc       <= '0;
      ovf_acc   <= 1'b0;
      beat_cnt  <= '0;
      a_out     <= '0;
      b_out     <= '0;
      valid_out <= 1'b0;
      y_out     <= '0;
      y_valid   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      valid_out <= valid_in;
      y_valid   <= 1'b0;
      if (valid_in) begin
        a_out <= a_in;
        b_out <= b_in;
      end
      if (closing) begin
        y_out    <= res;
        overflow <= ovf_acc | beat_ovf;
        y_valid  <= 1'b1;
        acc      <= '0;
        ovf_acc  <= 1'b0;
        beat_cnt <= '0;
        state    <= EMPTY;
      end else if (valid_in) begin
        acc      <= res;
        ovf_acc  <= ovf_acc | beat_ovf;
        beat_cnt <= beat_cnt + CW'(1);
        state    <= FILLING;
      end else if (flush && state == FILLING) begin
        y_out    <= acc;
        overflow <= ovf_acc;
        y_valid  <= 1'b1;
        acc      <= '0;
        ovf_acc  <= 1'b0;
        beat_cnt <= '0;
        state    <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_systolic_pe_k.sv
// Directed bench for systolic_pe_k: four parameterisations share one
// stimulus stream; each section resets and checks the relevant instance.
module tb_systolic_pe_k;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_in;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       flush;

  logic [7:0]  d_a, d_b;
  logic        d_vo, d_yv, d_ov;
  logic [31:0] d_y;
  logic [2:0]  d_bc;

  logic [7:0]  s_a, s_b;
  logic        s_vo, s_yv, s_ov;
  logic [15:0] s_y;
  logic [2:0]  s_bc;

  logic [7:0]  w_a, w_b;
  logic        w_vo, w_yv, w_ov;
  logic [15:0] w_y;
  logic [2:0]  w_bc;

  logic [7:0]  k_a, k_b;
  logic        k_vo, k_yv, k_ov;
  logic [31:0] k_y;
  logic [1:0]  k_bc;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  systolic_pe_k u_def (
    .clk(clk), .reset(rst_n), .valid_in(valid_in),
    .a_in(a_in), .b_in(b_in), .flush(flush),
    .a_out(d_a), .b_out(d_b), .valid_out(d_vo),
    .y_out(d_y), .y_valid(d_yv), .overflow(d_ov),
    .beat_cnt(d_bc)
  );

  systolic_pe_k #(.ACC_W(16), .SATURATE(1)) u_sat (
    .clk(clk), .reset(rst_n), .valid_in(valid_in),
    .a_in(a_in), .b_in(b_in), .flush(flush),
    .a_out(s_a), .b_out(s_b), .valid_out(s_vo),
    .y_out(s_y), .y_valid(s_yv), .overflow(s_ov),
    .beat_cnt(s_bc)
  );

  systolic_pe_k #(.ACC_W(16), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(rst_n), .valid_in(valid_in),
    .a_in(a_in), .b_in(b_in), .flush(flush),
    .a_out(w_a), .b_out(w_b), .valid_out(w_vo),
    .y_out(w_y), .y_valid(w_yv), .overflow(w_ov),
    .beat_cnt(w_bc)
  );

  systolic_pe_k #(.K_DEPTH(3), .SIGNED(0)) u_k3 (
    .clk(clk), .reset(rst_n), .valid_in(valid_in),
    .a_in(a_in), .b_in(b_in), .flush(flush),
    .a_out(k_a), .b_out(k_b), .valid_out(k_vo),
    .y_out(k_y), .y_valid(k_yv), .overflow(k_ov),
    .beat_cnt(k_bc)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [7:0] a,
                      input logic [7:0] b, input logic f);
    valid_in = v;
    a_in     = a;
    b_in     = b;
    flush    = f;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 8'd0, 8'd0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 8'd0, 8'd0, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    a_in     = '0;
    b_in     = '0;
    flush    = 1'b0;

    // Reset and idle
    #1;
    check("rst_a_out", 32'(d_a), 32'd0);
    check("rst_y_out", d_y, 32'd0);
    check("rst_y_valid", 32'(d_yv), 32'd0);
    check("rst_beat_cnt", 32'(d_bc), 32'd0);
    step(1'b0, 8'd0, 8'd0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'd0, 8'd0, 1'b0);
      check("idle_y_valid", 32'(d_yv), 32'd0);
    end
    check("idle_ovf", 32'(d_ov), 32'd0);
    check("idle_vout", 32'(d_vo), 32'd0);

    // Basic signed tile: 2+12-30-56 = -72
    step(1'b1, 8'd1, 8'd2, 1'b0);
    check("fwd_a1", 32'(d_a), 32'h01);
    check("fwd_b1", 32'(d_b), 32'h02);
    check("fwd_v1", 32'(d_vo), 32'd1);
    step(1'b1, 8'd3, 8'd4, 1'b0);
    check("bc_2", 32'(d_bc), 32'd2);
    check("yv_mid", 32'(d_yv), 32'd0);
    step(1'b1, 8'hFB, 8'd6, 1'b0);
    check("fwd_a3", 32'(d_a), 32'hFB);
    step(1'b1, 8'd7, 8'hF8, 1'b0);
    check("basic_yv", 32'(d_yv), 32'd1);
    check("basic_y", d_y, 32'hFFFF_FFB8);
    check("basic_ovf", 32'(d_ov), 32'd0);
    check("basic_bc0", 32'(d_bc), 32'd0);
    check("fwd_b4", 32'(d_b), 32'hF8);
    step(1'b0, 8'h55, 8'h66, 1'b0);
    check("pulse_end", 32'(d_yv), 32'd0);
    check("y_hold", d_y, 32'hFFFF_FFB8);
    check("a_hold", 32'(d_a), 32'h07);
    check("b_hold", 32'(d_b), 32'hF8);
    check("vout_low", 32'(d_vo), 32'd0);

    // 4 x 127*127 = 64516: clamps at 16 bits, wraps to 0xFC04 (-1020)
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'd127, 8'd127, 1'b0);
    check("sat_yv", 32'(s_yv), 32'd1);
    check("sat_y", 32'(s_y), 32'h0000_7FFF);
    check("sat_ovf", 32'(s_ov), 32'd1);
    check("wrap_y", 32'(w_y), 32'h0000_FC04);
    check("wrap_ovf", 32'(w_ov), 32'd1);
    check("wide_y", d_y, 32'd64516);
    check("wide_ovf", 32'(d_ov), 32'd0);

    // Flush without a beat, flush with a beat, flush on empty tile
    step(1'b0, 8'd0, 8'd0, 1'b0);
    step(1'b1, 8'd2, 8'd3, 1'b0);
    step(1'b1, 8'd4, 8'd5, 1'b0);
    check("fl_pre", 32'(d_yv), 32'd0);
    step(1'b0, 8'd0, 8'd0, 1'b1);
    check("fl_yv", 32'(d_yv), 32'd1);
    check("fl_y", d_y, 32'd26);
    check("fl_ovf", 32'(d_ov), 32'd0);
    check("fl_bc0", 32'(d_bc), 32'd0);
    step(1'b1, 8'd2, 8'd2, 1'b0);
    check("fl2_pre", 32'(d_yv), 32'd0);
    step(1'b1, 8'd1, 8'd1, 1'b1);
    check("fl2_yv", 32'(d_yv), 32'd1);
    check("fl2_y", d_y, 32'd5);
    step(1'b0, 8'd0, 8'd0, 1'b1);
    check("fl_empty_yv", 32'(d_yv), 32'd0);
    check("fl_empty_y", d_y, 32'd5);

    // Continuous unsigned stream, K_DEPTH=3: tiles of i-2, i-1, i
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 8'(i), 8'd1, 1'b0);
      if (i % 3 == 0) begin
        check("k3_yv", 32'(k_yv), 32'd1);
        check("k3_y", k_y, 32'(3*i - 3));
      end else begin
        check("k3_gap", 32'(k_yv), 32'd0);
      end
    end
    step(1'b1, 8'd1, 8'd1, 1'b0);
    step(1'b0, 8'd0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 8'd0, 1'b0);
    check("k3_hold_bc", 32'(k_bc), 32'd1);
    check("k3_hold_yv", 32'(k_yv), 32'd0);
    step(1'b1, 8'd2, 8'd1, 1'b0);
    step(1'b1, 8'd3, 8'd1, 1'b0);
    check("k3_gapped_yv", 32'(k_yv), 32'd1);
    check("k3_gapped_y", k_y, 32'd6);

    // Reset mid-tile discards the partial sum
    do_reset();
    step(1'b1, 8'd5, 8'd5, 1'b0);
    step(1'b1, 8'd6, 8'd6, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_a0", 32'(d_a), 32'd0);
    check("mid_bc0", 32'(d_bc), 32'd0);
    check("mid_vo0", 32'(d_vo), 32'd0);
    step(1'b0, 8'd0, 8'd0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 8'd0, 8'd0, 1'b0);
    check("mid_no_yv", 32'(d_yv), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'd1, 8'd1, 1'b0);
    check("mid_new_yv", 32'(d_yv), 32'd1);
    check("mid_new_y", d_y, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
